// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: 2-bit direction counter and table entry.
package btb_pkg;

  // Widest tag the table ever holds (ENTRIES >= 4 leaves at most 28 tag bits).
  localparam int TAG_MAX_W = 28;

  typedef enum logic [1:0] {
    CTR_SN = 2'b00,
    CTR_WN = 2'b01,
    CTR_WT = 2'b10,
    CTR_ST = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    ctr_e                 ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      CTR_SN: nxt = taken ? CTR_WN : CTR_SN;
      CTR_WN: nxt = taken ? CTR_WT : CTR_SN;
      CTR_WT: nxt = taken ? CTR_ST : CTR_WN;
      CTR_ST: nxt = taken ? CTR_ST : CTR_WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch lookup, EX resolution and restore signals between the pipeline and btb_predictor.
interface btb_predictor_if;

  logic [31:0] i_pc;
  logic        o_pc_sel_btb;
  logic [31:0] o_predict_br_pc;
  logic [31:0] o_predict_pc;

  logic        i_clr;
  logic        i_upd_en;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;

  logic        o_restore_pc;
  logic        o_pc_sel;
  logic [31:0] o_br_pc_real;
  logic [31:0] o_pc_real;
  logic [31:0] o_mispred_cnt;

  modport slave (
    input  i_pc, i_clr, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target,
           i_upd_pred_taken, i_upd_pred_target,
    output o_pc_sel_btb, o_predict_br_pc, o_predict_pc, o_restore_pc,
           o_pc_sel, o_br_pc_real, o_pc_real, o_mispred_cnt
  );

  modport master (
    output i_pc, i_clr, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target,
           i_upd_pred_taken, i_upd_pred_target,
    input  o_pc_sel_btb, o_predict_br_pc, o_predict_pc, o_restore_pc,
           o_pc_sel, o_br_pc_real, o_pc_real, o_mispred_cnt
  );

endinterface

// File: rtl/btb_table.sv
// Direct-mapped entry storage: async lookup read, write port that also exposes the
// entry it is about to overwrite, and a bulk valid clear that wins over the write.
module btb_table
  import btb_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [IDX_W-1:0] i_rd_idx,
  output btb_entry_t       o_rd_entry,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  btb_entry_t       i_wr_entry,
  output btb_entry_t       o_wr_cur
);

  btb_entry_t mem_q [ENTRIES];
  btb_entry_t mem_d [ENTRIES];

  assign o_rd_entry = mem_q[i_rd_idx];
  assign o_wr_cur   = mem_q[i_wr_idx];

  always_comb begin
    mem_d = mem_q;
    if (i_clr) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_d[i].valid = 1'b0;
      end
    end else if (i_wr_en) begin
      mem_d[i_wr_idx] = i_wr_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// BTB + 2-bit direction predictor: 0-cycle lookup, update on the resolution edge,
// combinational restore request on a wrong direction or wrong taken target.
module btb_predictor
  import btb_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  btb_predictor_if.slave bus
);

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       lk_entry;
  btb_entry_t       up_cur;
  btb_entry_t       up_new;
  logic             lk_hit;
  logic             up_hit;
  logic             up_wr_en;
  logic             restore;
  logic [31:0]      cnt_q;
  logic [31:0]      cnt_d;
  logic [3:0]       unused_pc_bits;

  assign unused_pc_bits = {bus.i_pc[1:0], bus.i_upd_pc[1:0]};

  assign lk_idx = bus.i_pc[IDX_W+1:2];
  assign lk_tag = bus.i_pc[31:IDX_W+2];
  assign up_idx = bus.i_upd_pc[IDX_W+1:2];
  assign up_tag = bus.i_upd_pc[31:IDX_W+2];

  btb_table #(.ENTRIES(ENTRIES)) u_table (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (bus.i_clr),
    .i_rd_idx   (lk_idx),
    .o_rd_entry (lk_entry),
    .i_wr_en    (up_wr_en),
    .i_wr_idx   (up_idx),
    .i_wr_entry (up_new),
    .o_wr_cur   (up_cur)
  );

  assign lk_hit               = lk_entry.valid && (lk_entry.tag == TAG_MAX_W'(lk_tag));
  assign bus.o_pc_sel_btb     = lk_hit && lk_entry.ctr[1];
  assign bus.o_predict_br_pc  = lk_hit ? lk_entry.target : 32'h0;
  assign bus.o_predict_pc     = bus.i_pc;

  // Not-taken branches never compare targets: the fall-through was already correct.
  assign restore = bus.i_upd_en &&
                   ((bus.i_upd_pred_taken != bus.i_upd_taken) ||
                    (bus.i_upd_taken && (bus.i_upd_pred_target != bus.i_upd_target)));

  assign bus.o_restore_pc  = restore;
  assign bus.o_pc_sel      = bus.i_upd_taken;
  assign bus.o_br_pc_real  = bus.i_upd_target;
  assign bus.o_pc_real     = bus.i_upd_pc;
  assign bus.o_mispred_cnt = cnt_q;

  assign up_hit   = up_cur.valid && (up_cur.tag == TAG_MAX_W'(up_tag));
  assign up_wr_en = bus.i_upd_en && (up_hit || bus.i_upd_taken);

  always_comb begin
    up_new = up_cur;
    if (up_hit) begin
      up_new.ctr = ctr_next(up_cur.ctr, bus.i_upd_taken);
      if (bus.i_upd_taken) begin
        up_new.target = bus.i_upd_target;
      end
    end else begin
      up_new.valid  = 1'b1;
      up_new.tag    = TAG_MAX_W'(up_tag);
      up_new.target = bus.i_upd_target;
      up_new.ctr    = CTR_WT;
    end
  end

  assign cnt_d = cnt_q + 32'(restore);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES=16): lookup, hysteresis, aliasing, clear, reset.
module tb_btb_predictor;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  btb_predictor_if bus ();

  btb_predictor #(.ENTRIES(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic en, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.i_upd_en          = en;
    bus.i_upd_pc          = pc;
    bus.i_upd_taken       = tk;
    bus.i_upd_target      = tgt;
    bus.i_upd_pred_taken  = ptk;
    bus.i_upd_pred_target = ptgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_sel, input logic [31:0] exp_tgt);
    bus.i_pc = pc;
    #1;
    chk({tag, "_sel"}, {31'h0, bus.o_pc_sel_btb}, {31'h0, exp_sel});
    chk({tag, "_tgt"}, bus.o_predict_br_pc, exp_tgt);
  endtask

  task automatic chk_restore(input string tag, input logic exp);
    #1;
    chk(tag, {31'h0, bus.o_restore_pc}, {31'h0, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_pc  = 32'h100;
    bus.i_clr = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();

    // Reset state
    look("rst_lk", 32'h100, 1'b0, 32'h0);
    chk("rst_ppc", bus.o_predict_pc, 32'h100);
    chk("rst_restore", {31'h0, bus.o_restore_pc}, 32'h0);
    chk("rst_cnt", bus.o_mispred_cnt, 32'h0);
    rst_n = 1'b1;
    tick();

    // First allocation: predicted not-taken, actually taken to 0x200
    upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    chk_restore("alloc_restore", 1'b1);
    chk("alloc_pcsel", {31'h0, bus.o_pc_sel}, 32'h1);
    chk("alloc_brreal", bus.o_br_pc_real, 32'h200);
    chk("alloc_pcreal", bus.o_pc_real, 32'h100);
    look("alloc_sameclk", 32'h100, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alloc_cnt", bus.o_mispred_cnt, 32'd1);
    look("alloc_hit", 32'h100, 1'b1, 32'h200);
    chk("alloc_ppc", bus.o_predict_pc, 32'h100);

    // Hysteresis: WT -> WN
    upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    chk_restore("wn_restore", 1'b1);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wn_cnt", bus.o_mispred_cnt, 32'd2);
    look("wn_lk", 32'h100, 1'b0, 32'h200);

    // WN -> WT (mispredicted), WT -> ST, ST stays ST
    upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h200);
    chk_restore("wt_restore", 1'b1);
    tick();
    look("wt_lk", 32'h100, 1'b1, 32'h200);
    upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    chk_restore("st_restore", 1'b0);
    tick();
    chk_restore("st2_restore", 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("st_cnt", bus.o_mispred_cnt, 32'd3);

    // ST -> WT still predicts taken
    upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sat_cnt", bus.o_mispred_cnt, 32'd4);
    look("sat_lk", 32'h100, 1'b1, 32'h200);

    // Right direction, wrong target: WT -> ST, target becomes 0x204
    upd(1'b1, 32'h100, 1'b1, 32'h204, 1'b1, 32'h200);
    chk_restore("tgt_restore", 1'b1);
    chk("tgt_brreal", bus.o_br_pc_real, 32'h204);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("tgt_cnt", bus.o_mispred_cnt, 32'd5);
    look("tgt_lk", 32'h100, 1'b1, 32'h204);

    // Not-taken miss on the same index: no restore, no allocation
    upd(1'b1, 32'h180, 1'b0, 32'h999, 1'b0, 32'h444);
    chk_restore("ntmiss_restore", 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b1, 32'h1, 1'b0, 32'h2);
    chk_restore("noen_restore", 1'b0);
    look("ntmiss_lk", 32'h180, 1'b0, 32'h0);
    look("ntmiss_keep", 32'h100, 1'b1, 32'h204);
    chk("ntmiss_cnt", bus.o_mispred_cnt, 32'd5);

    // Alias: 0x140 replaces 0x100 at index 0; 0x104 goes to index 1
    upd(1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    upd(1'b1, 32'h104, 1'b1, 32'h400, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alias_cnt", bus.o_mispred_cnt, 32'd7);
    look("alias_old", 32'h100, 1'b0, 32'h0);
    look("alias_new", 32'h140, 1'b1, 32'h300);
    look("alias_idx1", 32'h104, 1'b1, 32'h400);

    // Clear with a same-cycle taken update: update dropped, counter still counts
    bus.i_clr = 1'b1;
    upd(1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0);
    chk_restore("clr_restore", 1'b1);
    tick();
    bus.i_clr = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("clr_cnt", bus.o_mispred_cnt, 32'd8);
    look("clr_100", 32'h100, 1'b0, 32'h0);
    look("clr_140", 32'h140, 1'b0, 32'h0);
    look("clr_104", 32'h104, 1'b0, 32'h0);

    // Reset mid-run with an update in flight
    upd(1'b1, 32'h108, 1'b1, 32'h600, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("pre_rst_lk", 32'h108, 1'b1, 32'h600);
    chk("pre_rst_cnt", bus.o_mispred_cnt, 32'd9);
    upd(1'b1, 32'h10C, 1'b1, 32'h700, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_cnt", bus.o_mispred_cnt, 32'd0);
    look("rst_async_lk", 32'h108, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();
    look("post_rst_108", 32'h108, 1'b0, 32'h0);
    look("post_rst_10c", 32'h10C, 1'b0, 32'h0);
    chk("post_rst_cnt", bus.o_mispred_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Branch target buffer and 2-bit direction predictor feeding the next-PC selection stage. Each cycle it looks up the fetch PC and supplies the predicted target and predict-taken flag. It accepts branch resolutions from EX, updates its table and raises the restore request with corrected PC operands when a prediction was wrong. Direct-mapped, single lookup port and single update port.

## Interface
- ENTRIES, 16, number of table entries; power of two, 4..256
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden)
- TAG_W, 30-IDX_W, tag width (derived)
---
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pc  in  32  fetch-stage PC to predict
- o_pc_sel_btb  out  1  predict taken (hit and counter[1]=1)
- o_predict_br_pc  out  32  predicted target; 0 when no hit
- o_predict_pc  out  32  equals i_pc; next-PC stage adds 4 when not taken
- i_clr  in  1  synchronous invalidate of all entries (fence.i)
- i_upd_en  in  1  EX resolved a branch/jump this cycle
- i_upd_pc  in  32  PC of resolved instruction
- i_upd_taken  in  1  actual direction
- i_upd_target  in  32  actual target
- i_upd_pred_taken  in  1  o_pc_sel_btb carried down the pipe with the instruction
- i_upd_pred_target  in  32  o_predict_br_pc carried down the pipe
- o_restore_pc  out  1  misprediction; next-PC stage must take corrected PC
- o_pc_sel  out  1  = i_upd_taken
- o_br_pc_real  out  32  = i_upd_target
- o_pc_real  out  32  = i_upd_pc
- o_mispred_cnt  out  32  mispredictions since reset, wraps at 2^32

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target[31:0], ctr[1:0] (00 SN, 01 WN, 10 WT, 11 ST).
- Lookup (combinational): hit = valid && tag match; o_pc_sel_btb = hit && ctr[1]; o_predict_br_pc = hit ? target : 0.
- Mispredict (combinational, qualified by i_upd_en): o_restore_pc = i_upd_en && ((i_upd_pred_taken != i_upd_taken) || (i_upd_taken && i_upd_pred_target != i_upd_target)). o_pc_sel/o_br_pc_real/o_pc_real pass through unconditionally.
- Table update at posedge when i_upd_en:
  - hit: ctr saturating +1 if taken, -1 if not; if taken, target <= i_upd_target.
  - miss and taken: allocate/replace: valid=1, tag, target, ctr=10.
  - miss and not taken: no write.
- o_mispred_cnt increments by 1 at posedge when o_restore_pc=1.
- i_clr: all valid <= 0 at posedge; has priority over a same-cycle update (update dropped); o_mispred_cnt not cleared.

## Timing
- Lookup 0-cycle latency; update visible to lookups from the cycle after the write edge.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents.
- o_restore_pc is combinational in the resolution cycle; the next-PC stage consumes it same cycle.
- Reset: all valid=0, tag/target/ctr=0, o_mispred_cnt=0; hence o_pc_sel_btb=0, o_predict_br_pc=0, o_restore_pc=0 while i_upd_en=0.
- Reset mid-operation: in-flight update discarded; table empty after release.
- Stalls are handled downstream; the block ignores stall, and the caller must not assert i_upd_en twice for one instruction.

## Structure
- btb_pkg: ctr_e enum (SN/WN/WT/ST), btb_entry_t struct, function ctr_next(ctr_e, taken) with saturation.
- Sub-module btb_table: register-array storage with one async-read port and one write port plus bulk valid clear. btb_predictor holds the hit/mispredict logic and the counter.

## Test plan
- After reset, i_pc=0x100 -> o_pc_sel_btb=0, o_predict_br_pc=0, o_predict_pc=0x100.
- Update pc=0x100 taken target=0x200 (pred_taken=0) -> o_restore_pc=1 same cycle, o_mispred_cnt=1; next cycle i_pc=0x100 -> o_pc_sel_btb=1, o_predict_br_pc=0x200.
- Counter hysteresis on 0x100 (ctr=WT): one not-taken update -> ctr=WN, o_pc_sel_btb=0; two taken -> ST; a third taken stays ST; one not-taken -> WT still predicts taken.
- Alias with ENTRIES=16: 0x140 taken to 0x300 replaces 0x100 (same index) -> i_pc=0x100 misses and i_pc=0x140 hits 0x300. Not-taken miss at 0x180 -> no allocation.
- Correct direction but wrong target (pred 0x200, actual 0x204, both taken) -> o_restore_pc=1, o_br_pc_real=0x204, entry target updated.
- i_clr with a same-cycle taken update at 0x100 -> next cycle every lookup misses, update dropped. Assert i_rst_n low mid-run -> o_mispred_cnt=0 and the table is empty.
